// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Decides, every cycle, whether the external PC register loads and what value
// it loads: boot address, sequential pc_q+4, branch target, jump target or the
// trap vector. It also drives the instruction fetch request, a one-cycle
// flush pulse after every redirect, and captures the exception PC.
//
// Parameters
//   N         PC width in bits
//   RESET_PC  boot address
//   TRAP_VEC  trap handler address (never alignment-checked)
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   pc_q       in   current PC register output
//   imem_ready in   instruction memory accepted the fetch at pc_q
//   stall      in   downstream cannot accept a new instruction
//   br_taken   in   conditional branch resolved taken
//   br_target  in   branch target
//   jmp_valid  in   JAL/JALR redirect
//   jmp_target in   jump target
//   trap       in   exception/ecall request
//   pc_d       out  PC register D input (equals pc_q whenever pc_load=0)
//   pc_load    out  PC register load enable
//   imem_req   out  fetch request at pc_q
//   flush      out  discard the in-flight instruction
//   epc        out  PC captured at the last trap or misaligned redirect
//   misalign   out  one-cycle pulse: redirect target had bits [1:0] != 0
//   state_dbg  out  current FSM state (0=BOOT 1=FETCH 2=STALL 3=FLUSH)
//
// Fetch handshake: imem_req is the valid, imem_ready the ready. A fetch at
// pc_q completes in the cycle where both are high; the PC advances by 4 on
// that edge. While imem_req is high and imem_ready is low, pc_q is held and
// imem_req stays high until accepted, stalled or redirected.
//
// All outputs except epc are combinational from state and inputs. While rst
// is high the outputs look exactly like BOOT, so the PC register is loaded
// with RESET_PC during reset regardless of the (possibly unknown) state.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0040_0000,
  parameter logic [N-1:0] TRAP_VEC = 32'h0040_0180
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc_q,
  input  logic         imem_ready,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         jmp_valid,
  input  logic [N-1:0] jmp_target,
  input  logic         trap,
  output logic [N-1:0] pc_d,
  output logic         pc_load,
  output logic         imem_req,
  output logic         flush,
  output logic [N-1:0] epc,
  output logic         misalign,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Redirect selection
  logic         redirect;
  logic [N-1:0] sel_target;
  logic         target_bad;
  logic [N-1:0] redirect_pc;
  logic         capture_epc;
  logic         take_redirect;

  assign state_dbg = state;

  // Priority trap > jump > branch. A misaligned jump/branch target is turned
  // into a trap: the PC goes to TRAP_VEC and epc records the faulting pc_q.
  always_comb begin
    redirect = trap | jmp_valid | br_taken;
    if (trap) begin
      sel_target = TRAP_VEC;
    end else if (jmp_valid) begin
      sel_target = jmp_target;
    end else begin
      sel_target = br_target;
    end
    target_bad  = !trap && (jmp_valid || br_taken) && (sel_target[1:0] != 2'b00);
    redirect_pc = target_bad ? TRAP_VEC : sel_target;
    capture_epc = trap | target_bad;
  end

  always_comb begin
    pc_d          = pc_q;
    pc_load       = 1'b0;
    imem_req      = 1'b0;
    flush         = 1'b0;
    misalign      = 1'b0;
    take_redirect = 1'b0;
    state_next    = state;

    if (rst) begin
      pc_load    = 1'b1;
      pc_d       = RESET_PC;
      state_next = BOOT;
    end else begin
      case (state)
        BOOT: begin
          pc_load    = 1'b1;
          pc_d       = RESET_PC;
          state_next = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (redirect) begin
            take_redirect = 1'b1;
            state_next    = FLUSH;
          end else if (stall) begin
            // Stall beats imem_ready: the PC must not advance.
            state_next = STALL;
          end else if (imem_ready) begin
            pc_load = 1'b1;
            pc_d    = pc_q + N'(4);
          end
        end
        STALL: begin
          if (redirect) begin
            take_redirect = 1'b1;
            state_next    = FLUSH;
          end else if (!stall) begin
            state_next = FETCH;
          end
        end
        FLUSH: begin
          // Redirects arriving here are intentionally dropped.
          flush      = 1'b1;
          state_next = FETCH;
        end
        default: begin
          state_next = BOOT;
        end
      endcase

      if (take_redirect) begin
        pc_load  = 1'b1;
        pc_d     = redirect_pc;
        misalign = target_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      epc   <= '0;
    end else begin
      state <= state_next;
      if (take_redirect && capture_epc) begin
        epc <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Bench for pc_sequencer. The bench owns the PC register (loads pc_d when
// pc_load is high) and feeds it back as pc_q. Each driven cycle pushes the
// expected {pc_load, pc_d, imem_req, flush, misalign} onto exp_q; a monitor
// pops and compares it at the falling edge of the same cycle. Test tasks also
// check pc_q, epc and the FSM state inline.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int W = 36;
  localparam logic [31:0] RP = 32'h0040_0000;
  localparam logic [31:0] TV = 32'h0040_0180;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic [31:0] pc_q;
  logic        imem_ready;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        trap;
  logic [31:0] pc_d;
  logic        pc_load;
  logic        imem_req;
  logic        flush;
  logic [31:0] epc;
  logic        misalign;
  logic [1:0]  state_dbg;

  pc_sequencer #(
    .N(32),
    .RESET_PC(RP),
    .TRAP_VEC(TV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_q(pc_q),
    .imem_ready(imem_ready),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
    .jmp_valid(jmp_valid),
    .jmp_target(jmp_target),
    .trap(trap),
    .pc_d(pc_d),
    .pc_load(pc_load),
    .imem_req(imem_req),
    .flush(flush),
    .epc(epc),
    .misalign(misalign),
    .state_dbg(state_dbg)
  );

  // External PC register
  logic [31:0] pc_reg;
  always @(posedge clk) begin
    if (pc_load) pc_reg <= pc_d;
  end
  assign pc_q = pc_reg;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    sb_run       = 0;
  int    sb_fail      = 0;
  string cur_name     = "idle";

  function automatic logic [W-1:0] e(input logic ld, input logic [31:0] d,
                                     input logic req, input logic fl, input logic mis);
    return {ld, d, req, fl, mis};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] want;
    logic [W-1:0] got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {pc_load, pc_d, imem_req, flush, misalign};
      sb_run++;
      if (got !== want) begin
        sb_fail++;
        $display("FAIL %s outputs: got load=%b d=%h req=%b flush=%b mis=%b, expected load=%b d=%h req=%b flush=%b mis=%b",
                 cur_name, got[35], got[34:3], got[2], got[1], got[0],
                 want[35], want[34:3], want[2], want[1], want[0]);
      end
    end
  end

  // Driver: apply inputs just after the rising edge, queue the expected
  // outputs, and return at the falling edge where they are sampled.
  task automatic drive(input logic r, input logic rdy, input logic stl,
                       input logic br, input logic [31:0] brt,
                       input logic jv, input logic [31:0] jt,
                       input logic tr, input logic [W-1:0] want);
    @(posedge clk);
    #1;
    rst        = r;
    imem_ready = rdy;
    stall      = stl;
    br_taken   = br;
    br_target  = brt;
    jmp_valid  = jv;
    jmp_target = jt;
    trap       = tr;
    exp_q.push_back(want);
    @(negedge clk);
  endtask

  task automatic test_reset;
    cur_name = "reset";
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, e(1, RP, 0, 0, 0));
    tests_run++;
    if (epc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_epc: got %h expected %h", epc, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(1, RP, 0, 0, 0));
    tests_run++;
    if (state_dbg !== S_BOOT) begin
      tests_failed++;
      $display("FAIL reset_boot_state: got %0d expected %0d", state_dbg, S_BOOT);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, RP, 1, 0, 0));
    tests_run++;
    if (pc_q !== RP || state_dbg !== S_FETCH) begin
      tests_failed++;
      $display("FAIL first_fetch: got pc=%h st=%0d expected pc=%h st=%0d", pc_q, state_dbg, RP, S_FETCH);
    end
  endtask

  task automatic test_sequential;
    cur_name = "sequential";
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, e(1, RP + 32'(4 * (i + 1)), 1, 0, 0));
      tests_run++;
      if (pc_q !== RP + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL seq_pc%0d: got %h expected %h", i, pc_q, RP + 32'(4 * i));
      end
    end
    cur_name = "wait_ready";
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, RP + 32'h10, 1, 0, 0));
      tests_run++;
      if (pc_q !== RP + 32'h10) begin
        tests_failed++;
        $display("FAIL hold_pc%0d: got %h expected %h", i, pc_q, RP + 32'h10);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] p;
    p = RP + 32'h10;
    cur_name = "stall";
    drive(0, 1, 1, 0, 0, 0, 0, 0, e(0, p, 1, 0, 0));
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0, 0, e(0, p, 0, 0, 0));
      tests_run++;
      if (state_dbg !== S_STALL || pc_q !== p) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got st=%0d pc=%h expected st=%0d pc=%h", i, state_dbg, pc_q, S_STALL, p);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, p, 0, 0, 0));
    cur_name = "stall_resume";
    drive(0, 1, 0, 0, 0, 0, 0, 0, e(1, p + 32'h4, 1, 0, 0));
    tests_run++;
    if (pc_q !== p || state_dbg !== S_FETCH) begin
      tests_failed++;
      $display("FAIL stall_resume: got pc=%h st=%0d expected pc=%h st=%0d", pc_q, state_dbg, p, S_FETCH);
    end
  endtask

  task automatic test_branch;
    logic [31:0] t;
    t = 32'h0040_0100;
    cur_name = "branch";
    drive(0, 0, 0, 1, t, 0, 0, 0, e(1, t, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, t, 0, 1, 0));
    tests_run++;
    if (pc_q !== t || state_dbg !== S_FLUSH) begin
      tests_failed++;
      $display("FAIL branch_target: got pc=%h st=%0d expected pc=%h st=%0d", pc_q, state_dbg, t, S_FLUSH);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, e(1, t + 32'h4, 1, 0, 0));
    cur_name = "branch_with_stall";
    drive(0, 0, 1, 1, t, 0, 0, 0, e(1, t, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, t, 0, 1, 0));
    tests_run++;
    if (pc_q !== t) begin
      tests_failed++;
      $display("FAIL branch_stall_target: got %h expected %h", pc_q, t);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, t, 1, 0, 0));
    cur_name = "branch_from_stall";
    drive(0, 0, 1, 0, 0, 0, 0, 0, e(0, t, 1, 0, 0));
    drive(0, 0, 1, 1, 32'h0040_0200, 0, 0, 0, e(1, 32'h0040_0200, 0, 0, 0));
    cur_name = "flush_ignores_redirect";
    drive(0, 0, 0, 1, 32'h0040_0300, 0, 0, 0, e(0, 32'h0040_0200, 0, 1, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, 32'h0040_0200, 1, 0, 0));
    tests_run++;
    if (pc_q !== 32'h0040_0200) begin
      tests_failed++;
      $display("FAIL flush_ignores_redirect: got %h expected %h", pc_q, 32'h0040_0200);
    end
  endtask

  task automatic test_priority_trap;
    logic [31:0] p;
    p = 32'h0040_0020;
    cur_name = "jump_setup";
    drive(0, 0, 0, 0, 0, 1, p, 0, e(1, p, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, p, 0, 1, 0));
    cur_name = "trap_priority";
    drive(0, 1, 0, 1, 32'h0040_0500, 1, 32'h0040_0400, 1, e(1, TV, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, TV, 0, 1, 0));
    tests_run++;
    if (pc_q !== TV || epc !== p) begin
      tests_failed++;
      $display("FAIL trap_priority: got pc=%h epc=%h expected pc=%h epc=%h", pc_q, epc, TV, p);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, TV, 1, 0, 0));
    cur_name = "jump_over_branch";
    drive(0, 0, 0, 1, 32'h0040_0700, 1, 32'h0040_0600, 0, e(1, 32'h0040_0600, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, 32'h0040_0600, 0, 1, 0));
    tests_run++;
    if (pc_q !== 32'h0040_0600 || epc !== p) begin
      tests_failed++;
      $display("FAIL jump_over_branch: got pc=%h epc=%h expected pc=%h epc=%h", pc_q, epc, 32'h0040_0600, p);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, 32'h0040_0600, 1, 0, 0));
  endtask

  task automatic test_misalign;
    cur_name = "misaligned_jump";
    drive(0, 1, 0, 0, 0, 1, 32'h0040_0102, 0, e(1, TV, 1, 0, 1));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, TV, 0, 1, 0));
    tests_run++;
    if (pc_q !== TV || epc !== 32'h0040_0600) begin
      tests_failed++;
      $display("FAIL misaligned_jump: got pc=%h epc=%h expected pc=%h epc=%h", pc_q, epc, TV, 32'h0040_0600);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, TV, 1, 0, 0));
    cur_name = "misaligned_branch";
    drive(0, 0, 0, 1, 32'h0040_0801, 0, 0, 0, e(1, TV, 1, 0, 1));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, TV, 0, 1, 0));
    tests_run++;
    if (epc !== TV) begin
      tests_failed++;
      $display("FAIL misaligned_branch_epc: got %h expected %h", epc, TV);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, TV, 1, 0, 0));
  endtask

  task automatic test_wrap;
    cur_name = "wrap";
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, e(1, 32'hFFFF_FFFC, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, 32'hFFFF_FFFC, 0, 1, 0));
    drive(0, 1, 0, 0, 0, 0, 0, 0, e(1, 32'h0000_0000, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, 32'h0000_0000, 1, 0, 0));
    tests_run++;
    if (pc_q !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_pc: got %h expected %h", pc_q, 32'h0);
    end
  endtask

  task automatic test_reset_in_flush;
    cur_name = "reset_in_flush";
    drive(0, 0, 0, 0, 0, 1, 32'h0040_0040, 0, e(1, 32'h0040_0040, 1, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, 0, e(1, RP, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(1, RP, 0, 0, 0));
    tests_run++;
    if (state_dbg !== S_BOOT || epc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_in_flush: got st=%0d epc=%h expected st=%0d epc=%h", state_dbg, epc, S_BOOT, 32'h0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, e(0, RP, 1, 0, 0));
    tests_run++;
    if (pc_q !== RP) begin
      tests_failed++;
      $display("FAIL reset_in_flush_fetch: got %h expected %h", pc_q, RP);
    end
  endtask

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    jmp_valid  = 1'b0;
    jmp_target = '0;
    trap       = 1'b0;

    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_priority_trap();
    test_misalign();
    test_wrap();
    test_reset_in_flush();

    @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    tests_run    += sb_run;
    tests_failed += sb_fail;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the RISC-V program-counter register: each cycle it decides whether the PC register loads and selects the value it loads (boot address, sequential PC+4, branch target, jump target or trap vector). It sits between the branch/jump/trap sources, the instruction-memory fetch handshake and the PC register. It also owns the fetch request, the post-redirect flush pulse and the exception-PC capture.

## Interface
Parameters:
- N, 32, PC width in bits
- RESET_PC, 32'h0040_0000, boot address (4194304)
- TRAP_VEC, 32'h0040_0180, trap handler address

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_q  in  N  current PC register output
- imem_ready  in  1  instruction memory accepted the fetch at pc_q this cycle
- stall  in  1  downstream cannot accept a new instruction
- br_taken  in  1  conditional branch resolved taken
- br_target  in  N  branch target
- jmp_valid  in  1  JAL/JALR redirect
- jmp_target  in  N  jump target
- trap  in  1  exception/ecall request
- pc_d  out  N  value for the PC register D input
- pc_load  out  1  PC register load enable
- imem_req  out  1  fetch request at pc_q
- flush  out  1  discard the in-flight instruction
- epc  out  N  PC captured at the last trap or misaligned redirect
- misalign  out  1  one-cycle pulse: a redirect target had bits [1:0] != 0

## Operation
- FSM states: BOOT, FETCH, STALL, FLUSH.
- BOOT: pc_load=1, pc_d=RESET_PC, imem_req=0. Always -> FETCH next cycle, ignoring all other inputs.
- FETCH: imem_req=1.
  - Redirect present: see redirect rule below; -> FLUSH.
  - Else stall=1: pc_load=0; -> STALL.
  - Else imem_ready=1: pc_load=1, pc_d=pc_q+4; stay FETCH.
  - Else: pc_load=0, imem_req held high, pc_q unchanged; stay FETCH.
- STALL: imem_req=0, pc_load=0. Redirect -> FLUSH via the redirect rule. Else stall=0 -> FETCH. Else stay STALL.
- FLUSH: flush=1, imem_req=0, pc_load=0; redirect inputs ignored; -> FETCH.
- Redirect rule (FETCH or STALL), priority trap > jmp_valid > br_taken:
  - Selected target is TRAP_VEC, jmp_target or br_target; pc_load=1, pc_d=target.
  - trap: epc <= pc_q.
  - Jump/branch target with [1:0] != 0: treated as a trap. pc_d=TRAP_VEC, epc <= pc_q, misalign=1 that cycle.
  - A redirect overrides stall and imem_ready.
- Arithmetic: pc_q+4 is an N-bit add and wraps modulo 2^N (e.g. all-ones-minus-3 -> 0). TRAP_VEC is not checked for alignment.
- Outputs default to 0 unless stated; pc_d=pc_q whenever pc_load=0.

## Timing
- Reset: while rst=1, next state is BOOT and epc <= 0. Reset mid-operation aborts any state, including FLUSH.
- Outputs during and one cycle after reset (in BOOT): pc_load=1, pc_d=RESET_PC, imem_req=0, flush=0, misalign=0, epc=0.
- First fetch: imem_req rises in the second cycle after rst falls, with pc_q=RESET_PC.
- All outputs are combinational from state and inputs, except epc, which is registered and updates on the redirect edge.
- Redirect latency: target appears on pc_q the cycle after the redirect. Flush is high that same cycle. Fetch at the target starts one cycle later.
- Back-to-back: a redirect presented during FLUSH is lost. Producers hold it only one cycle; the pipeline guarantees none arrive there.
- Simultaneous events:
  - trap with br_taken: trap wins and epc is captured.
  - stall with imem_ready and no redirect: stall wins and the PC does not advance.

## Test plan
- Reset: hold rst 3 cycles, release -> pc_load=1 with pc_d=0x00400000 in BOOT. Next cycle imem_req=1 with pc_q=0x00400000. epc=0.
- Sequential fetch: imem_ready=1 for 4 cycles -> pc_q steps 0x00400004, 08, 0C, 10. With imem_ready=0 for 2 cycles -> pc_q held and imem_req stays 1.
- Stall: stall=1 for 3 cycles at pc 0x00400010 -> STALL, pc_load=0, imem_req=0. On release, fetch resumes at 0x00400010.
- Branch: br_taken=1, br_target=0x00400100 -> pc_q=0x00400100 next cycle with flush=1. Fetch resumes the cycle after. Repeat with stall=1 also asserted -> same result.
- Priority and trap: trap, jmp_valid and br_taken together at pc 0x00400020 -> pc_q=0x00400180, epc=0x00400020, misalign=0.
- Misaligned and wrap: jmp_target=0x00400102 -> pc_q=0x00400180, misalign pulse, epc=current pc. Separately, pc_q=0xFFFFFFFC with imem_ready=1 -> pc_q=0x00000000. Asserting rst during FLUSH -> BOOT with no flush the next cycle.
